ws2812_pixel_capture: RTL and testbench

Parametrised WS2812 pixel capture stage that sits between the bit decoder and the LED output driver. It shifts decoded bits into a sentinel-tracked register. It captures up to NUM_PIXELS consecutive pixels of BITS_PER_PIXEL bits each, emitting a one-cycle strobe and index per pixel. After the last pixel it switches to passthrough so downstream LEDs in the chain receive the remaining stream. A treset (latch) pulse re-arms it for the next frame.

---
 rtl/ws2812_pixel_capture.sv | 126 ++++++++++++
 tb/tb_ws2812_pixel_capture.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_pixel_capture.sv
// WS2812 pixel capture: sentinel-tracked shift register, per-pixel strobe, passthrough after last pixel.
// Optional macro SHIFT_REG_ERRCHK_EN enables the sticky o_short_frame check.
module ws2812_pixel_capture #(
  parameter int BITS_PER_PIXEL = 24,
  parameter int NUM_PIXELS     = 1,
  localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_shift_en,
  input  logic                      i_decode_bit,
  input  logic                      i_treset,
  output logic [BITS_PER_PIXEL-1:0] o_led_data,
  output logic                      o_pixel_valid,
  output logic [IDX_W-1:0]          o_pixel_index,
  output logic                      o_passthru_en,
  output logic                      o_short_frame
);

  localparam int B = BITS_PER_PIXEL;
  localparam logic [B:0]     SENT = {{B{1'b0}}, 1'b1};
  localparam logic [IDX_W:0] ONE  = {{IDX_W{1'b0}}, 1'b1};
  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    S_SHIFT = 2'b01,
    S_PASS  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [B:0]       sr_q, sr_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [B-1:0]     data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [B:0]       nxt;

`ifdef SHIFT_REG_ERRCHK_EN
  logic short_q, short_d;
`endif

  assign nxt = {sr_q[B-1:0], i_decode_bit};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
`ifdef SHIFT_REG_ERRCHK_EN
    short_d = short_q;
`endif
    if (i_treset) begin
`ifdef SHIFT_REG_ERRCHK_EN
      if (state_q == S_SHIFT &&
          (sr_q != SENT || cnt_q != '0))
        short_d = 1'b1;
`endif
      sr_d    = SENT;
      cnt_d   = '0;
      state_d = S_SHIFT;
    end else begin
      case (state_q)
        S_SHIFT: begin
          if (i_shift_en) begin
            // sentinel reaching the MSB marks a full pixel
            if (nxt[B]) begin
              data_d  = nxt[B-1:0];
              idx_d   = cnt_q[IDX_W-1:0];
              valid_d = 1'b1;
              sr_d    = SENT;
              cnt_d   = cnt_q + ONE;
              if (cnt_q == LAST)
                state_d = S_PASS;
            end else begin
              sr_d = nxt;
            end
          end
        end
        S_PASS: sr_d = SENT;
        default: begin
          state_d = S_SHIFT;
          sr_d    = SENT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_SHIFT;
      sr_q    <= SENT;
      cnt_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
`ifdef SHIFT_REG_ERRCHK_EN
      short_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
`ifdef SHIFT_REG_ERRCHK_EN
      short_q <= short_d;
`endif
    end
  end

  assign o_led_data    = data_q;
  assign o_pixel_valid = valid_q;
  assign o_pixel_index = idx_q;
  assign o_passthru_en = (state_q == S_PASS);

`ifdef SHIFT_REG_ERRCHK_EN
  assign o_short_frame = short_q;
`else
  assign o_short_frame = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_pixel_capture.sv
// Bench for ws2812_pixel_capture: two instances (24b x1, 32b x3) checked
// against a bit/pixel-counting model plus literal expectations.
module tb_ws2812_pixel_capture;

`ifdef SHIFT_REG_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic sh [2];
  logic bt [2];
  logic tr [2];

  logic [23:0] a_data;
  logic        a_valid, a_pass, a_short;
  logic [0:0]  a_idx;
  logic [31:0] b_data;
  logic        b_valid, b_pass, b_short;
  logic [1:0]  b_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ws2812_pixel_capture u_a (
    .i_clk(clk), .i_reset(rst),
    .i_shift_en(sh[0]), .i_decode_bit(bt[0]), .i_treset(tr[0]),
    .o_led_data(a_data), .o_pixel_valid(a_valid),
    .o_pixel_index(a_idx), .o_passthru_en(a_pass),
    .o_short_frame(a_short)
  );

  ws2812_pixel_capture #(.BITS_PER_PIXEL(32), .NUM_PIXELS(3)) u_b (
    .i_clk(clk), .i_reset(rst),
    .i_shift_en(sh[1]), .i_decode_bit(bt[1]), .i_treset(tr[1]),
    .o_led_data(b_data), .o_pixel_valid(b_valid),
    .o_pixel_index(b_idx), .o_passthru_en(b_pass),
    .o_short_frame(b_short)
  );

  // model: count bits into an accumulator, count pixels, track passthrough
  int          BPP [2] = '{24, 32};
  int          NPX [2] = '{1, 3};
  int          m_bits [2];
  int          m_pix [2];
  int          m_idx [2];
  logic [31:0] m_acc [2];
  logic [31:0] m_data [2];
  bit          m_valid [2];
  bit          m_pass [2];
  bit          m_short [2];

  always @(posedge clk) begin : model
    int nb, np, ni;
    logic [31:0] na, nd;
    bit nv, npass, ns;
    for (int d = 0; d < 2; d++) begin
      nb = m_bits[d]; np = m_pix[d]; ni = m_idx[d];
      na = m_acc[d]; nd = m_data[d];
      nv = 1'b0; npass = m_pass[d]; ns = m_short[d];
      if (rst) begin
        nb = 0; np = 0; ni = 0; na = 0; nd = 0;
        npass = 1'b0; ns = 1'b0;
      end else if (tr[d]) begin
        if (ERRCHK && !npass && (nb != 0 || np > 0)) ns = 1'b1;
        nb = 0; na = 0; np = 0; npass = 1'b0;
      end else if (sh[d] && !npass) begin
        na = {na[30:0], bt[d]};
        nb = nb + 1;
        if (nb == BPP[d]) begin
          nd = na; ni = np; nv = 1'b1;
          np = np + 1; nb = 0; na = 0;
          if (np == NPX[d]) npass = 1'b1;
        end
      end
      m_bits[d]  <= nb;
      m_pix[d]   <= np;
      m_idx[d]   <= ni;
      m_acc[d]   <= na;
      m_data[d]  <= nd;
      m_valid[d] <= nv;
      m_pass[d]  <= npass;
      m_short[d] <= ns;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("a_valid", 32'(a_valid), 32'(m_valid[0]));
      cmp("a_data",  32'(a_data),  m_data[0]);
      cmp("a_idx",   32'(a_idx),   32'(m_idx[0]));
      cmp("a_pass",  32'(a_pass),  32'(m_pass[0]));
      cmp("a_short", 32'(a_short), 32'(m_short[0]));
      cmp("b_valid", 32'(b_valid), 32'(m_valid[1]));
      cmp("b_data",  b_data,       m_data[1]);
      cmp("b_idx",   32'(b_idx),   32'(m_idx[1]));
      cmp("b_pass",  32'(b_pass),  32'(m_pass[1]));
      cmp("b_short", 32'(b_short), 32'(m_short[1]));
    end
  end

  int          q_cyc [$];
  logic [31:0] q_dat [$];
  int          q_idx [$];
  bit          q_pas [$];

  always @(negedge clk) begin
    if (b_valid === 1'b1) begin
      q_cyc.push_back(cyc);
      q_dat.push_back(b_data);
      q_idx.push_back(int'(b_idx));
      q_pas.push_back(b_pass);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [31:0] v,
                      input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      sh[d] = 1'b1;
      bt[d] = v[i];
      step();
      sh[d] = 1'b0;
      bt[d] = 1'b0;
      if (i > 0) repeat (gap - 1) step();
    end
  endtask

  task automatic pulse_tr(input int d);
    tr[d] = 1'b1;
    step();
    tr[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      sh[d] = 1'b0; bt[d] = 1'b0; tr[d] = 1'b0;
    end
    step();
    chk_on = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    cmp("rst_a_data", 32'(a_data), 32'h0);
    cmp("rst_a_pass", 32'(a_pass), 32'h0);
    cmp("rst_b_valid", 32'(b_valid), 32'h0);

    // single pixel, slow strobes
    send(0, 32'hA5C33C, 24, 4);
    @(negedge clk);
    cmp("p0_valid", 32'(a_valid), 32'h1);
    cmp("p0_data",  32'(a_data),  32'hA5C33C);
    cmp("p0_idx",   32'(a_idx),   32'h0);
    cmp("p0_pass",  32'(a_pass),  32'h1);
    step();
    @(negedge clk);
    cmp("p0_valid_drop", 32'(a_valid), 32'h0);
    send(0, 32'h123456, 24, 1);
    @(negedge clk);
    cmp("pass_hold_data", 32'(a_data), 32'hA5C33C);

    // re-arm
    pulse_tr(0);
    @(negedge clk);
    cmp("tr_pass_drop", 32'(a_pass), 32'h0);
    send(0, 32'h000001, 24, 1);
    @(negedge clk);
    cmp("rearm_data", 32'(a_data), 32'h1);
    cmp("rearm_idx",  32'(a_idx),  32'h0);

    // three back-to-back 32-bit pixels
    q_cyc.delete(); q_dat.delete(); q_idx.delete(); q_pas.delete();
    send(1, 32'h11223344, 32, 1);
    send(1, 32'h55667788, 32, 1);
    send(1, 32'h99AABBCC, 32, 1);
    repeat (3) step();
    cmp("b2b_count", 32'(q_cyc.size()), 32'd3);
    if (q_cyc.size() == 3) begin
      cmp("b2b_gap01", 32'(q_cyc[1] - q_cyc[0]), 32'd32);
      cmp("b2b_gap12", 32'(q_cyc[2] - q_cyc[1]), 32'd32);
      cmp("b2b_d0", q_dat[0], 32'h11223344);
      cmp("b2b_d1", q_dat[1], 32'h55667788);
      cmp("b2b_d2", q_dat[2], 32'h99AABBCC);
      cmp("b2b_i2", 32'(q_idx[2]), 32'd2);
      cmp("b2b_pass1", 32'(q_pas[1]), 32'h0);
      cmp("b2b_pass2", 32'(q_pas[2]), 32'h1);
    end

    // treset colliding with a bit after a partial pixel
    pulse_tr(0);
    send(0, 32'h155, 10, 1);
    sh[0] = 1'b1; bt[0] = 1'b0; tr[0] = 1'b1;
    step();
    sh[0] = 1'b0; tr[0] = 1'b0;
    send(0, 32'hFFFFFF, 24, 1);
    @(negedge clk);
    cmp("coll_valid", 32'(a_valid), 32'h1);
    cmp("coll_data",  32'(a_data),  32'hFFFFFF);
    cmp("coll_short", 32'(a_short), 32'(ERRCHK));

    // reset partway through pixel 1
    pulse_tr(1);
    send(1, 32'hDEADBEEF, 32, 1);
    send(1, 32'hABC, 12, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    cmp("mid_rst_data",  b_data,          32'h0);
    cmp("mid_rst_idx",   32'(b_idx),      32'h0);
    cmp("mid_rst_valid", 32'(b_valid),    32'h0);
    cmp("mid_rst_short", 32'(a_short),    32'h0);
    send(1, 32'hCAFEF00D, 32, 1);
    @(negedge clk);
    cmp("post_rst_data", b_data,     32'hCAFEF00D);
    cmp("post_rst_idx",  32'(b_idx), 32'h0);

    // partial-frame treset
    send(0, 32'h1B, 5, 1);
    pulse_tr(0);
    @(negedge clk);
    cmp("partial_short", 32'(a_short), 32'(ERRCHK));

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
